// File: rtl/approx_mult_pkg.sv
// Shared types and constants for the approximate-multiplier scheduler.
// Operand width comes from the BITWIDTH macro, defaulting to 8 when no header defines it.
`ifndef BITWIDTH
`define BITWIDTH 8
`endif

package approx_mult_pkg;

  localparam int unsigned BITWIDTH    = `BITWIDTH;
  localparam int unsigned PROD_W      = 2 * BITWIDTH;
  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned ID_W        = $clog2(DEF_NUM_REQ);

  typedef logic [PROD_W-1:0] prod_t;

  typedef struct packed {
    prod_t           p;
    logic [ID_W-1:0] id;
  } rsp_t;

  // Increment modulo n, for pointers whose range need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO whose head entry and flags are held in registers.
// A push into an empty FIFO becomes visible on the cycle after the push.
module sync_fifo
  import approx_mult_pkg::*;
#(
  parameter type         T     = logic [7:0],
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  T                 din,
  input  logic             pop,
  output T                 head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  T                 mem_q [DEPTH];
  T                 head_q, head_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_c, pop_c;

  assign pop_c  = pop && !empty_q;
  assign push_c = push && (!full_q || pop_c);

  // Next pointers/count, and the entry that will sit at the head after this edge.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = '0;
    if (push_c) wr_ptr_d = PTR_W'(wrap_inc(32'(wr_ptr_q), DEPTH));
    if (pop_c)  rd_ptr_d = PTR_W'(wrap_inc(32'(rd_ptr_q), DEPTH));
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (count_d != '0) begin
      head_d = (push_c && (wr_ptr_q == rd_ptr_d)) ? din : mem_q[rd_ptr_d];
    end
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign head  = head_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full_q && !pop));

endmodule

// File: rtl/approx_mult_sched.sv
// Round-robin scheduler sharing one fixed-latency multiplier datapath between requesters.
// Issue is credit-gated so every product in flight is guaranteed a result-FIFO slot.
module approx_mult_sched
  import approx_mult_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned MUL_LAT    = 3,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0][BITWIDTH-1:0] req_a,
  input  logic [NUM_REQ-1:0][BITWIDTH-1:0] req_b,
  output logic                             mul_valid,
  output logic [BITWIDTH-1:0]              mul_a,
  output logic [BITWIDTH-1:0]              mul_b,
  input  logic [PROD_W-1:0]                mul_p,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [PROD_W-1:0]                rsp_p,
  output logic [ID_W-1:0]                  rsp_id,
  output logic                             busy
);

  localparam int unsigned CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  logic [ID_W-1:0]                 ptr_q, ptr_d;
  logic [CRED_W-1:0]               credits_q, credits_d;
  logic                            mul_valid_q, mul_valid_d;
  logic [BITWIDTH-1:0]             mul_a_q, mul_a_d;
  logic [BITWIDTH-1:0]             mul_b_q, mul_b_d;
  logic [ID_W-1:0]                 mul_id_q, mul_id_d;
  logic [MUL_LAT-1:0]              sh_vld_q, sh_vld_d;
  logic [MUL_LAT-1:0][ID_W-1:0]    sh_id_q, sh_id_d;
  logic                            busy_q, busy_d;

  logic [ID_W-1:0]  gnt_id_c;
  logic             gnt_found_c;
  logic             issue_c;
  logic             push_c;
  logic             pop_c;
  rsp_t             push_data_c;
  rsp_t             fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // First valid requester scanning from the round-robin pointer.
  always_comb begin
    gnt_found_c = 1'b0;
    gnt_id_c    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      logic [ID_W-1:0] idx;
      idx = ID_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!gnt_found_c && req_valid[idx]) begin
        gnt_found_c = 1'b1;
        gnt_id_c    = idx;
      end
    end
  end

  assign issue_c   = rst_n && gnt_found_c && (credits_q != '0);
  assign req_ready = issue_c ? (NUM_REQ'(1) << gnt_id_c) : '0;

  assign push_c    = sh_vld_q[MUL_LAT-1];
  assign rsp_valid = !fifo_empty;
  assign pop_c     = rsp_valid && rsp_ready;

  always_comb begin
    push_data_c    = '0;
    push_data_c.p  = mul_p;
    push_data_c.id = sh_id_q[MUL_LAT-1];
  end

  // Issue register, shadow tag pipe and credit bookkeeping.
  always_comb begin
    ptr_d       = ptr_q;
    mul_valid_d = issue_c;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_id_d    = mul_id_q;
    credits_d   = credits_q;
    sh_vld_d    = '0;
    sh_id_d     = '0;
    if (issue_c) begin
      ptr_d    = (gnt_id_c == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_c + ID_W'(1);
      mul_a_d  = req_a[gnt_id_c];
      mul_b_d  = req_b[gnt_id_c];
      mul_id_d = gnt_id_c;
    end
    // Stage 0 follows mul_valid, so the last stage lines up with mul_p.
    sh_vld_d[0] = mul_valid_q;
    sh_id_d[0]  = mul_id_q;
    for (int unsigned i = 1; i < MUL_LAT; i++) begin
      sh_vld_d[i] = sh_vld_q[i-1];
      sh_id_d[i]  = sh_id_q[i-1];
    end
    case ({issue_c, pop_c})
      2'b10:   credits_d = credits_q - CRED_W'(1);
      2'b01:   credits_d = credits_q + CRED_W'(1);
      default: credits_d = credits_q;
    endcase
    busy_d = (credits_d != CRED_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      credits_q   <= CRED_W'(FIFO_DEPTH);
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_id_q    <= '0;
      sh_vld_q    <= '0;
      sh_id_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      credits_q   <= credits_d;
      mul_valid_q <= mul_valid_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_id_q    <= mul_id_d;
      sh_vld_q    <= sh_vld_d;
      sh_id_q     <= sh_id_d;
      busy_q      <= busy_d;
    end
  end

  sync_fifo #(
    .T     (rsp_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .din   (push_data_c),
    .pop   (pop_c),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign mul_valid = mul_valid_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_p     = fifo_head.p;
  assign rsp_id    = fifo_head.id;
  assign busy      = busy_q;

  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    ((32'(credits_q) + 32'(fifo_count)) <= FIFO_DEPTH) && !(fifo_full && (credits_q != '0)));

endmodule

// File: tb/tb_approx_mult_sched.sv
// Bench for approx_mult_sched: directed scenarios plus random traffic, checked each cycle
// against a transaction-level model (grant scan, credit limit, fixed response latency).
module tb_approx_mult_sched;
  import approx_mult_pkg::*;

  localparam int N       = 4;
  localparam int LAT     = 3;
  localparam int DEPTH   = 8;
  localparam int RSP_LAT = LAT + 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [N-1:0]              req_valid;
  logic [N-1:0]              req_ready;
  logic [N-1:0][BITWIDTH-1:0] req_a;
  logic [N-1:0][BITWIDTH-1:0] req_b;
  logic                      mul_valid;
  logic [BITWIDTH-1:0]       mul_a;
  logic [BITWIDTH-1:0]       mul_b;
  logic [PROD_W-1:0]         mul_p;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [PROD_W-1:0]         rsp_p;
  logic [ID_W-1:0]           rsp_id;
  logic                      busy;

  approx_mult_sched #(.NUM_REQ(N), .MUL_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_valid (mul_valid),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Exact multiplier standing in for the datapath: product appears LAT cycles after mul_valid.
  logic [PROD_W-1:0] p_pipe [LAT];
  always @(posedge clk) begin
    p_pipe[0] <= PROD_W'(mul_a) * PROD_W'(mul_b);
    for (int i = 1; i < LAT; i++) p_pipe[i] <= p_pipe[i-1];
  end
  assign mul_p = p_pipe[LAT-1];

  typedef struct {
    logic [PROD_W-1:0] p;
    logic [ID_W-1:0]   id;
    int                rdy;
  } exp_t;

  exp_t                sb[$];
  int                  ptr_m;
  int                  cyc;
  logic                prev_issue;
  logic [BITWIDTH-1:0] prev_a, prev_b;
  logic [N-1:0]        last_xfer;
  int                  checks;
  int                  passes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Compare one cycle's outputs with the model, then advance the model across the coming edge.
  task automatic check_cycle();
    int           g;
    logic         issue;
    logic [N-1:0] exp_ready;
    logic         exp_rv;
    if (!rst_n) begin
      sb.delete();
      ptr_m      = 0;
      prev_issue = 1'b0;
      last_xfer  = '0;
    end
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && req_valid[(ptr_m + k) % N]) g = (ptr_m + k) % N;
    end
    issue     = rst_n && (g >= 0) && (sb.size() < DEPTH);
    exp_ready = issue ? N'(1 << g) : '0;
    exp_rv    = (sb.size() > 0) && (sb[0].rdy <= cyc);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("mul_valid", 32'(mul_valid), 32'(prev_issue));
    if (prev_issue) begin
      chk("mul_a", 32'(mul_a), 32'(prev_a));
      chk("mul_b", 32'(mul_b), 32'(prev_b));
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      chk("rsp_p", 32'(rsp_p), 32'(sb[0].p));
      chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
    end
    chk("busy", 32'(busy), 32'(sb.size() > 0));
    if (!rst_n) begin
      chk("rst_mul_a", 32'(mul_a), 32'd0);
      chk("rst_mul_b", 32'(mul_b), 32'd0);
      chk("rst_rsp_p", 32'(rsp_p), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    end else begin
      prev_issue = issue;
      last_xfer  = exp_ready & req_valid;
      if (issue) begin
        prev_a = req_a[g];
        prev_b = req_b[g];
        sb.push_back('{p: PROD_W'(req_a[g]) * PROD_W'(req_b[g]), id: ID_W'(g), rdy: cyc + RSP_LAT});
        ptr_m = (g + 1) % N;
      end
      if (exp_rv && rsp_ready) void'(sb.pop_front());
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  // Requesters hold valid and data until accepted; otherwise take the wanted pattern with fresh data.
  task automatic drive(input logic [N-1:0] want);
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] || last_xfer[i]) begin
        req_valid[i] = want[i];
        req_a[i]     = BITWIDTH'($urandom);
        req_b[i]     = BITWIDTH'($urandom);
      end
    end
  endtask

  initial begin
    int n;
    checks     = 0;
    passes     = 0;
    cyc        = 0;
    ptr_m      = 0;
    prev_issue = 1'b0;
    prev_a     = '0;
    prev_b     = '0;
    last_xfer  = '0;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Single request from requester 0.
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    req_a[0]  = 8'h05;
    req_b[0]  = 8'h07;
    tick();
    req_valid = '0;
    repeat (7) tick();

    // All requesters valid, no back-pressure.
    repeat (16) begin drive(4'hF); tick(); end
    repeat (8) begin drive(4'h0); tick(); end

    // All valid with back-pressure: credits allow exactly DEPTH transfers.
    rsp_ready = 1'b0;
    n = 0;
    repeat (14) begin drive(4'hF); tick(); n += $countones(last_xfer); end
    chk("bp_transfers", 32'(n), 32'(DEPTH));
    rsp_ready = 1'b1;
    repeat (12) begin drive(4'hF); tick(); end

    // Single pop with the FIFO full admits exactly one new issue.
    rsp_ready = 1'b0;
    repeat (12) begin drive(4'hF); tick(); end
    rsp_ready = 1'b1;
    drive(4'hF);
    tick();
    n = $countones(last_xfer);
    rsp_ready = 1'b0;
    repeat (4) begin drive(4'hF); tick(); n += $countones(last_xfer); end
    chk("full_pop_issues", 32'(n), 32'd1);

    // Reset with work in flight and results queued.
    rsp_ready = 1'b1;
    repeat (3) begin drive(4'hF); tick(); end
    rsp_ready = 1'b0;
    repeat (3) begin drive(4'hF); tick(); end
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (8) tick();

    // Only requester 2 valid while the pointer sits at 3.
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    req_valid = 4'b0100;
    req_a[2]  = 8'hFF;
    req_b[2]  = 8'hFF;
    tick();
    req_valid = '0;
    repeat (7) tick();

    // Random traffic with random back-pressure.
    repeat (300) begin
      drive(N'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rsp_ready = 1'b1;
    repeat (14) begin drive(4'h0); tick(); end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
